// File: rtl/cv_ctrl_quad.sv
// rtl/cv_ctrl_quad.sv - ColecoVision controller interface, 1-4 ports, keypad/joystick select, quadrature spinner decoders
module cv_ctrl_quad #(
  parameter int NUM_PORTS = 2,
  parameter bit QUAD_EN   = 1'b1,
  parameter int COUNT_W   = 4,
  parameter int PSEL_W    = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clk_en_3m58_i,
  input  logic                 ctrl_en_key_n_i,
  input  logic                 ctrl_en_joy_n_i,
  input  logic [PSEL_W-1:0]    port_sel_i,
  input  logic                 rd_stb_i,
  input  logic [NUM_PORTS-1:0] ctrl_p1_i,
  input  logic [NUM_PORTS-1:0] ctrl_p2_i,
  input  logic [NUM_PORTS-1:0] ctrl_p3_i,
  input  logic [NUM_PORTS-1:0] ctrl_p4_i,
  input  logic [NUM_PORTS-1:0] ctrl_p6_i,
  input  logic [NUM_PORTS-1:0] ctrl_p7_i,
  input  logic [NUM_PORTS-1:0] ctrl_p9_i,
  input  logic [NUM_PORTS-1:0] quad_a_i,
  input  logic [NUM_PORTS-1:0] quad_b_i,
  output logic [NUM_PORTS-1:0] ctrl_p5_o,
  output logic [NUM_PORTS-1:0] ctrl_p8_o,
  output logic [7:0]           d_o,
  output logic                 int_n_o
);

  localparam int ACC_MAX = (1 << (COUNT_W - 1)) - 1;

  logic                 sel_q;
  logic [NUM_PORTS-1:0] qbit;
  logic                 unused_pins;

  // Pin 9 is wired through the connector but never appears on the data bus.
  assign unused_pins = ^ctrl_p9_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sel_q <= 1'b0;
    end else if (clk_en_3m58_i) begin
      if (!ctrl_en_key_n_i && ctrl_en_joy_n_i)
        sel_q <= 1'b0;
      else if (ctrl_en_key_n_i && !ctrl_en_joy_n_i)
        sel_q <= 1'b1;
    end
  end

  assign ctrl_p5_o = {NUM_PORTS{sel_q}};
  assign ctrl_p8_o = {NUM_PORTS{~sel_q}};

  always_comb begin
    d_o = 8'h7F;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(port_sel_i) == i)
        d_o = {1'b0, ctrl_p6_i[i], ctrl_p7_i[i], qbit[i],
               ctrl_p3_i[i], ctrl_p2_i[i], ctrl_p4_i[i], ctrl_p1_i[i]};
    end
  end

  if (QUAD_EN) begin : g_quad
    logic [NUM_PORTS-1:0]      a_s1, a_s2, b_s1, b_s2, a_prev;
    logic                      armed;
    logic                      int_n_q;
    logic                      any_nz;
    logic signed [COUNT_W-1:0] acc     [NUM_PORTS];
    logic signed [COUNT_W-1:0] acc_nxt [NUM_PORTS];

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        a_s1 <= '0;
        a_s2 <= '0;
        b_s1 <= '0;
        b_s2 <= '0;
      end else begin
        a_s1 <= quad_a_i;
        a_s2 <= a_s1;
        b_s1 <= quad_b_i;
        b_s2 <= b_s1;
      end
    end

    // Step and read-consume combine arithmetically, then saturate symmetrically.
    always_comb begin
      int cur;
      int sum;
      cur = 0;
      sum = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cur = int'(acc[i]);
        sum = cur;
        if (armed && a_s2[i] && !a_prev[i])
          sum = b_s2[i] ? sum - 1 : sum + 1;
        if (rd_stb_i && int'(port_sel_i) == i) begin
          if (cur > 0)
            sum = sum - 1;
          else if (cur < 0)
            sum = sum + 1;
        end
        if (sum > ACC_MAX)
          sum = ACC_MAX;
        else if (sum < -ACC_MAX)
          sum = -ACC_MAX;
        acc_nxt[i] = COUNT_W'(sum);
      end
    end

    always_comb begin
      any_nz = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++)
        if (acc[i] != '0)
          any_nz = 1'b1;
    end

    // The first enable after reset only captures A, so a level held through reset is not an edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        a_prev  <= '0;
        armed   <= 1'b0;
        int_n_q <= 1'b1;
        for (int i = 0; i < NUM_PORTS; i++)
          acc[i] <= '0;
      end else if (clk_en_3m58_i) begin
        a_prev  <= a_s2;
        armed   <= 1'b1;
        int_n_q <= ~any_nz;
        for (int i = 0; i < NUM_PORTS; i++)
          acc[i] <= acc_nxt[i];
      end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_qbit
      assign qbit[g] = ~acc[g][COUNT_W-1];
    end

    assign int_n_o = int_n_q;
  end else begin : g_noquad
    logic unused_quad;
    assign unused_quad = ^{quad_a_i, quad_b_i, rd_stb_i};
    assign qbit        = '1;
    assign int_n_o     = 1'b1;
  end

endmodule

// File: tb/tb_cv_ctrl_quad.sv
// tb/tb_cv_ctrl_quad.sv - self-checking bench for cv_ctrl_quad (3 ports, 4-bit accumulators)
module tb_cv_ctrl_quad;

  localparam int NP = 3;
  localparam int AMAX = 7;

  typedef struct {
    logic [1:0] sel;
    logic [2:0] p1, p2, p3, p4, p6, p7;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0;
  logic key_n = 1'b1, joy_n = 1'b1, rd_stb = 1'b0;
  logic [1:0] port_sel = 2'd0;
  logic [NP-1:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0, p6 = '0, p7 = '0, p9 = '0;
  logic [NP-1:0] qa = '0, qb = '0;
  logic [NP-1:0] p5, p8;
  logic [7:0] d;
  logic int_n;

  int n_pass = 0, n_total = 0;
  vec_t vecs[6];
  int macc[NP], nxt[NP];
  logic [NP-1:0] ha1, ha2, hb1;
  int expd, exp_int, v, s;

  cv_ctrl_quad #(.NUM_PORTS(NP), .QUAD_EN(1'b1), .COUNT_W(4), .PSEL_W(2)) dut (
    .clk_i(clk), .reset_i(reset), .clk_en_3m58_i(clk_en),
    .ctrl_en_key_n_i(key_n), .ctrl_en_joy_n_i(joy_n),
    .port_sel_i(port_sel), .rd_stb_i(rd_stb),
    .ctrl_p1_i(p1), .ctrl_p2_i(p2), .ctrl_p3_i(p3), .ctrl_p4_i(p4),
    .ctrl_p6_i(p6), .ctrl_p7_i(p7), .ctrl_p9_i(p9),
    .quad_a_i(qa), .quad_b_i(qb),
    .ctrl_p5_o(p5), .ctrl_p8_o(p8), .d_o(d), .int_n_o(int_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic int acc_of(input int p);
    case (p)
      0:       return int'(dut.g_quad.acc[0]);
      1:       return int'(dut.g_quad.acc[1]);
      default: return int'(dut.g_quad.acc[2]);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One enable followed by two idle clocks; inputs stay applied across the idle clocks.
  task automatic tick();
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic spin(input int p, input logic b);
    qa[p] = 1'b1; qb[p] = b;
    tick(); tick();
    qa[p] = 1'b0;
    tick(); tick();
  endtask

  task automatic rd(input int p, input int exp_q, input int exp_acc);
    port_sel = 2'(p); rd_stb = 1'b1; #1;
    check("read_qbit", int'(d[4]), exp_q);
    tick();
    rd_stb = 1'b0;
    check("read_acc", acc_of(p), exp_acc);
  endtask

  initial begin
    vecs[0] = '{2'd2, 3'b100, 3'b011, 3'b100, 3'b011, 3'b100, 3'b011, 8'h59};
    vecs[1] = '{2'd0, 3'b110, 3'b001, 3'b001, 3'b110, 3'b110, 3'b001, 8'h3C};
    vecs[2] = '{2'd1, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 8'h10};
    vecs[3] = '{2'd3, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 8'h7F};
    vecs[4] = '{2'd1, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 8'h11};
    vecs[5] = '{2'd2, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 8'h50};

    // Reset with spinner A held high on port 0
    qa = 3'b001;
    repeat (3) @(posedge clk); #1;
    check("reset_p5", int'(p5), 0);
    check("reset_p8", int'(p8), 7);
    check("reset_int_n", int'(int_n), 1);
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    tick(); tick(); tick();
    check("a_high_release_acc", acc_of(0), 0);
    check("a_high_release_int_n", int'(int_n), 1);
    qa = '0;
    tick(); tick();
    check("a_fall_acc", acc_of(0), 0);

    for (int i = 0; i < 6; i++) begin
      port_sel = vecs[i].sel;
      p1 = vecs[i].p1; p2 = vecs[i].p2; p3 = vecs[i].p3;
      p4 = vecs[i].p4; p6 = vecs[i].p6; p7 = vecs[i].p7;
      #1;
      check($sformatf("mux_vec%0d", i), int'(d), int'(vecs[i].exp));
    end

    // Select flip-flop
    key_n = 1'b1; joy_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("sel_no_enable", int'(p5), 0);
    tick();
    check("sel_set_p5", int'(p5), 7);
    check("sel_set_p8", int'(p8), 0);
    key_n = 1'b1; joy_n = 1'b1; tick();
    check("sel_hold11", int'(p5), 7);
    key_n = 1'b0; joy_n = 1'b0; tick();
    check("sel_hold00", int'(p5), 7);
    key_n = 1'b0; joy_n = 1'b1; tick();
    check("sel_clr_p5", int'(p5), 0);
    check("sel_clr_p8", int'(p8), 7);
    key_n = 1'b1; joy_n = 1'b1;

    // Clockwise on port 0, interrupt latency, consume reads
    qa[0] = 1'b1; qb[0] = 1'b0;
    tick(); tick();
    check("cw_first_acc", acc_of(0), 1);
    check("cw_int_latency", int'(int_n), 1);
    qa[0] = 1'b0; tick();
    check("cw_int_asserted", int'(int_n), 0);
    tick();
    spin(0, 1'b0); spin(0, 1'b0);
    check("cw_acc3", acc_of(0), 3);
    rd(0, 1, 2); rd(0, 1, 1); rd(0, 1, 0);
    check("drain_int_still", int'(int_n), 0);
    tick();
    check("drain_int_clear", int'(int_n), 1);

    // Counter-clockwise saturation on port 1
    repeat (10) spin(1, 1'b1);
    check("ccw_sat", acc_of(1), -AMAX);
    port_sel = 2'd1; #1;
    check("ccw_qbit", int'(d[4]), 0);
    rd(1, 0, -6);

    // Simultaneous step and consume on port 2
    spin(2, 1'b0); spin(2, 1'b0);
    check("sim_pre", acc_of(2), 2);
    qa[2] = 1'b1; qb[2] = 1'b0; tick();
    port_sel = 2'd2; rd_stb = 1'b1; tick(); rd_stb = 1'b0;
    check("sim_pos", acc_of(2), 2);
    qa[2] = 1'b0; tick(); tick();
    rd(2, 1, 1); rd(2, 1, 0);
    qa[2] = 1'b1; qb[2] = 1'b1; tick();
    port_sel = 2'd2; rd_stb = 1'b1; tick(); rd_stb = 1'b0;
    check("sim_zero", acc_of(2), -1);
    qa[2] = 1'b0; tick(); tick();

    // Asynchronous reset clears pending state
    repeat (5) spin(0, 1'b0);
    check("pre_reset_acc", acc_of(0), 5);
    check("pre_reset_int", int'(int_n), 0);
    reset = 1'b1; #2;
    check("async_rst_acc0", acc_of(0), 0);
    check("async_rst_acc1", acc_of(1), 0);
    check("async_rst_int", int'(int_n), 1);
    qa = '0; qb = '0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    tick(); tick();

    // Randomised traffic against a behavioural model
    for (int p = 0; p < NP; p++) macc[p] = 0;
    ha1 = '0; ha2 = '0; hb1 = '0;
    for (int it = 0; it < 300; it++) begin
      qa = NP'($urandom); qb = NP'($urandom);
      p1 = NP'($urandom); p2 = NP'($urandom); p3 = NP'($urandom);
      p4 = NP'($urandom); p6 = NP'($urandom); p7 = NP'($urandom); p9 = NP'($urandom);
      port_sel = 2'($urandom); rd_stb = 1'($urandom);
      #1;
      s = int'(port_sel);
      if (s < NP)
        expd = int'({1'b0, p6[s], p7[s], (macc[s] >= 0), p3[s], p2[s], p4[s], p1[s]});
      else
        expd = 8'h7F;
      check("rnd_d", int'(d), expd);
      exp_int = 1;
      for (int p = 0; p < NP; p++) begin
        if (macc[p] != 0) exp_int = 0;
        v = macc[p];
        if (ha1[p] && !ha2[p]) v = hb1[p] ? v - 1 : v + 1;
        if (rd_stb && s == p) v = v - (macc[p] > 0 ? 1 : (macc[p] < 0 ? -1 : 0));
        if (v > AMAX) v = AMAX;
        if (v < -AMAX) v = -AMAX;
        nxt[p] = v;
      end
      tick();
      check("rnd_int_n", int'(int_n), exp_int);
      for (int p = 0; p < NP; p++) begin
        check($sformatf("rnd_acc%0d", p), acc_of(p), nxt[p]);
        macc[p] = nxt[p];
      end
      ha2 = ha1; ha1 = qa; hb1 = qb;
    end
    rd_stb = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
